alu_wb_buffer: RTL and testbench
================================

# alu_wb_buffer

Two-entry elastic buffer between the combinational ALU result and the register-file writeback port. It captures each ALU result with its destination register and write-enable, computes zero and negative flags at capture, and presents entries in order to writeback over a valid/ready handshake. It decouples ALU issue from writeback stalls, and its handshake has no combinational ready path.

## Interface
- DATA_W, 32, result width; must match the ALU result width.
- RADDR_W, 5, destination register index width.
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  ALU result on in_* is valid this cycle.
- in_ready  output  1  buffer can accept an entry this cycle.
- in_result  input  DATA_W  ALU result.
- in_rd  input  RADDR_W  destination register index.
- in_we  input  1  entry writes the register file.
- out_valid  output  1  head entry valid.
- out_ready  input  1  writeback consumes the head entry this cycle.
- out_result  output  DATA_W  head entry result.
- out_rd  output  RADDR_W  head entry destination.
- out_we  output  1  head entry write-enable, after x0 suppression.
- out_zero  output  1  head result == 0.
- out_neg  output  1  head result bit DATA_W-1.
- count  output  2  occupancy, 0..2.
- stall_cnt  output  16  saturating stall-cycle counter (see Configuration).

## Operation
- Storage is 2 entries, each holding {result, rd, we, zero, neg}, with 1-bit read and write pointers that wrap 1→0.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (count != 2). It depends only on registered state; there is no path from out_ready to in_ready.
- out_valid = (count != 0). The out_* data fields always reflect the entry at the read pointer.
- Capture-time computation:
  - zero = (in_result == 0).
  - neg = in_result[DATA_W-1].
  - Stored we = in_we && (in_rd != 0), because x0 is never written.
- Occupancy updates:
  - Push only: count+1.
  - Pop only: count−1.
  - Push and pop in the same cycle (legal only when count==1): count stays 1. The new entry becomes head on the following cycle.
- Push with in_valid while full cannot occur because in_ready=0. The upstream stage must hold its data until in_ready.
- Pop with out_ready while empty does nothing.
- Entries leave in arrival order. Data is never reordered, dropped, or duplicated.
- While an entry is held unpopped, all out_* fields stay stable.

## Timing
- Latency is 1 cycle: an entry pushed at edge N is visible on out_* after edge N. There is no same-cycle bypass.
- Full throughput is 1 entry/cycle when out_ready is held high.
- rst takes effect at the clock edge and overrides any push or pop in that cycle. After reset:
  - count=0, out_valid=0, in_ready=1.
  - Both pointers are 0.
  - out_result, out_rd, out_we, out_zero, out_neg are all 0.
  - stall_cnt=0.
- Reset mid-operation discards all buffered entries, and no writeback occurs for them.
- Storage contents are zeroed on reset, so out_* reads 0 while empty.

## Configuration
- WB_STATS_EN defined: stall_cnt increments by 1 on every cycle with out_valid && !out_ready. It saturates at 16'hFFFF and clears only on rst.
- WB_STATS_EN undefined: the counter logic is compiled out and stall_cnt is tied to 0. The port list is unchanged.

## Test plan
- Reset, then out_ready=1; push result 32'h0000_0005, rd=3, we=1 → next cycle out_valid=1, out_result=5, out_rd=3, out_we=1, out_zero=0, out_neg=0; count returns to 0 one cycle later.
- out_ready=0; push 32'h8000_0000 then 32'h0 → count=2, in_ready=0; out_neg=1 on the first entry. Raise out_ready → the entries drain in order, and the second shows out_zero=1.
- count=1 with push and pop in the same cycle, streaming 10 back-to-back results → count stays 1, all 10 appear in order, no bubbles.
- Push rd=0 with we=1 → out_we=0, and out_result is still presented.
- Fill to 2, assert rst while in_valid=1 → next cycle count=0, out_valid=0, all out_* are 0, and the pushed data is not retained.
- With WB_STATS_EN, hold one entry with out_ready=0 for 7 cycles → stall_cnt=7. Without the macro → stall_cnt=0.

Source files
------------

// File: rtl/alu_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : alu_wb_buffer
// Purpose  : Two-entry elastic buffer between the ALU result and the
//            register-file writeback port. It captures {result, rd, we} and
//            computes zero/neg flags at capture time. It presents entries in
//            arrival order over a valid/ready handshake. in_ready depends only
//            on registered occupancy.
// Options  : WB_STATS_EN - when defined, enables the saturating stall-cycle
//            counter on stall_cnt. When undefined, stall_cnt is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module alu_wb_buffer #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_result,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_we,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_result,
  output logic [RADDR_W-1:0] out_rd,
  output logic               out_we,
  output logic               out_zero,
  output logic               out_neg,
  output logic [1:0]         count,
  output logic [15:0]        stall_cnt
);

  localparam logic [1:0] C_FULL  = 2'd2;
  localparam logic [1:0] C_EMPTY = 2'd0;

  // Entry storage, indexed by the 1-bit pointers
  logic [DATA_W-1:0]  result_q [2];
  logic [RADDR_W-1:0] rd_q     [2];
  logic               we_q     [2];
  logic               zero_q   [2];
  logic               neg_q    [2];

  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count_q;

  logic push;
  logic pop;
  logic cap_we;
  logic cap_zero;
  logic cap_neg;

  // Handshake and capture-time flag computation
  always_comb begin
    in_ready  = (count_q != C_FULL);
    out_valid = (count_q != C_EMPTY);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    // Register x0 is hard-wired, so never request a write to it
    cap_we    = in_we && (in_rd != '0);
    cap_zero  = (in_result == '0);
    cap_neg   = in_result[DATA_W-1];
  end

  // Storage, pointers and occupancy; reset discards every buffered entry
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        result_q[i] <= '0;
        rd_q[i]     <= '0;
        we_q[i]     <= 1'b0;
        zero_q[i]   <= 1'b0;
        neg_q[i]    <= 1'b0;
      end
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= C_EMPTY;
    end else begin
      // A popped slot is cleared so out_* reads 0 whenever the buffer is
      // empty. A simultaneous push always targets the other slot, because
      // push+pop is only possible at count==1.
      if (pop) begin
        result_q[rd_ptr] <= '0;
        rd_q[rd_ptr]     <= '0;
        we_q[rd_ptr]     <= 1'b0;
        zero_q[rd_ptr]   <= 1'b0;
        neg_q[rd_ptr]    <= 1'b0;
        rd_ptr           <= ~rd_ptr;
      end
      if (push) begin
        result_q[wr_ptr] <= in_result;
        rd_q[wr_ptr]     <= in_rd;
        we_q[wr_ptr]     <= cap_we;
        zero_q[wr_ptr]   <= cap_zero;
        neg_q[wr_ptr]    <= cap_neg;
        wr_ptr           <= ~wr_ptr;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Head entry is always presented straight from storage; there is no bypass
  always_comb begin
    out_result = result_q[rd_ptr];
    out_rd     = rd_q[rd_ptr];
    out_we     = we_q[rd_ptr];
    out_zero   = zero_q[rd_ptr];
    out_neg    = neg_q[rd_ptr];
    count      = count_q;
  end

`ifdef WB_STATS_EN
  logic [15:0] stall_q;

  // Count cycles where a valid head entry is held back by writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_wb_buffer
// Purpose  : Self-checking bench for alu_wb_buffer. The expected entries come
//            from a vector table and are queued when pushed. They are popped
//            and compared when the buffer hands them to writeback.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_wb_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [4:0]  in_rd;
  logic        in_we;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_zero;
  logic        out_neg;
  logic [1:0]  count;
  logic [15:0] stall_cnt;

  alu_wb_buffer #(.DATA_W(32), .RADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_rd(in_rd), .in_we(in_we),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_we(out_we),
    .out_zero(out_zero), .out_neg(out_neg),
    .count(count), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        we;
    logic        exp_we;
    logic        exp_zero;
    logic        exp_neg;
  } vec_t;

  vec_t tab[10];
  vec_t exp_q[$];

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic vec_t mk(input logic [31:0] r, input logic [4:0] d, input logic w,
                              input logic ew, input logic ez, input logic en);
    vec_t v;
    v.result = r; v.rd = d; v.we = w;
    v.exp_we = ew; v.exp_zero = ez; v.exp_neg = en;
    return v;
  endfunction

  // Drive one entry and hold it until accepted; returns #1 after the push edge
  task automatic send(input vec_t v);
    bit ok;
    ok        = 1'b0;
    in_valid  = 1'b1;
    in_result = v.result;
    in_rd     = v.rd;
    in_we     = v.we;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(v);
        ok = 1'b1;
      end
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Scoreboard: compare every entry writeback consumes against the queue
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 32'd1, 32'd0);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        chk("out_result", out_result, e.result);
        chk("out_rd",     {27'd0, out_rd}, {27'd0, e.rd});
        chk("out_we",     {31'd0, out_we}, {31'd0, e.exp_we});
        chk("out_zero",   {31'd0, out_zero}, {31'd0, e.exp_zero});
        chk("out_neg",    {31'd0, out_neg}, {31'd0, e.exp_neg});
      end
    end
  end

  task automatic chk_idle(input string tag);
    chk({tag, "_count"},     {30'd0, count}, 32'd0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_in_ready"},  {31'd0, in_ready}, 32'd1);
    chk({tag, "_out_result"}, out_result, 32'd0);
    chk({tag, "_out_rd"},    {27'd0, out_rd}, 32'd0);
    chk({tag, "_out_we"},    {31'd0, out_we}, 32'd0);
    chk({tag, "_out_zero"},  {31'd0, out_zero}, 32'd0);
    chk({tag, "_out_neg"},   {31'd0, out_neg}, 32'd0);
    chk({tag, "_stall_cnt"}, {16'd0, stall_cnt}, 32'd0);
  endtask

  initial begin
    logic [15:0] exp_stall;

    //            result         rd  we  exp_we zero neg
    tab[0] = mk(32'h0000_0001,  1, 1,  1, 0, 0);
    tab[1] = mk(32'hFFFF_FFFF, 31, 1,  1, 0, 1);
    tab[2] = mk(32'h0000_0000,  2, 1,  1, 1, 0);
    tab[3] = mk(32'h1234_5678,  0, 1,  0, 0, 0);
    tab[4] = mk(32'h8000_0001,  4, 0,  0, 0, 1);
    tab[5] = mk(32'h7FFF_FFFF,  5, 1,  1, 0, 0);
    tab[6] = mk(32'h0000_0000,  0, 0,  0, 1, 0);
    tab[7] = mk(32'hDEAD_BEEF,  7, 1,  1, 0, 1);
    tab[8] = mk(32'h0000_0100,  8, 1,  1, 0, 0);
    tab[9] = mk(32'hA5A5_0000,  9, 1,  1, 0, 1);

    rst = 1'b1; in_valid = 1'b0; in_result = '0; in_rd = '0; in_we = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_idle("reset");

    // Single entry, 1-cycle latency, drains the cycle after
    out_ready = 1'b1;
    send(mk(32'h0000_0005, 3, 1, 1, 0, 0));
    chk("t1_count", {30'd0, count}, 32'd1);
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    chk("t1_count_after", {30'd0, count}, 32'd0);

    // Fill to two with writeback stalled, then drain in order
    out_ready = 1'b0;
    send(mk(32'h8000_0000, 10, 1, 1, 0, 1));
    send(mk(32'h0000_0000, 11, 1, 1, 1, 0));
    chk("t2_count_full", {30'd0, count}, 32'd2);
    chk("t2_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t2_head_neg", {31'd0, out_neg}, 32'd1);
    @(posedge clk); #1;
    chk("t2_head_stable", out_result, 32'h8000_0000);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t2_drained", {30'd0, count}, 32'd0);

    // Back-to-back stream: occupancy holds at 1 with no bubbles
    for (int i = 0; i < 10; i++) begin
      send(tab[i]);
      chk("t3_count_one", {30'd0, count}, 32'd1);
      chk("t3_out_valid", {31'd0, out_valid}, 32'd1);
    end
    @(posedge clk); #1;
    chk("t3_drained", {30'd0, count}, 32'd0);

    // Reset while full and while a push is offered discards everything
    out_ready = 1'b0;
    send(mk(32'h1111_1111, 12, 1, 1, 0, 0));
    send(mk(32'h2222_2222, 13, 1, 1, 0, 0));
    chk("t5_count_full", {30'd0, count}, 32'd2);
    in_valid = 1'b1; in_result = 32'h3333_3333; in_rd = 5'd14; in_we = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    chk_idle("midreset");
    @(posedge clk); #1;
    chk("t5_still_empty", {31'd0, out_valid}, 32'd0);

    // Stall counter: hold one entry for 7 cycles
    send(mk(32'h0000_0042, 6, 1, 1, 0, 0));
    repeat (7) @(posedge clk);
    #1;
`ifdef WB_STATS_EN
    exp_stall = 16'd7;
`else
    exp_stall = 16'd0;
`endif
    chk("t6_stall_cnt", {16'd0, stall_cnt}, {16'd0, exp_stall});
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_drained", {30'd0, count}, 32'd0);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
